fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/fifo_wr_arbiter_rr_picker.sv | 19 +
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int ERR_CNT_W  = 16;
  localparam int RR_MAX_REQ = 16;

  // First set bit of valid[n-1:0] at or above ptr, wrapping modulo n; -1 if none.
  // Scans offsets high to low so the smallest offset is the one that sticks.
  function automatic int rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                 input int n, input int ptr);
    int k;
    rr_pick = -1;
    for (int i = RR_MAX_REQ-1; i >= 0; i--) begin
      k = ptr + i;
      if (k >= n) k = k - n;
      if (i < n && ((valid >> k) & 16'd1) != 16'd0) rr_pick = k;
    end
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index searching upward from ptr.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    found = rr_pick(RR_MAX_REQ'(valid), NUM_REQ, int'(ptr)) >= 0;
    idx   = ID_W'(rr_pick(RR_MAX_REQ'(valid), NUM_REQ, int'(ptr)));
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bounded bursts, full-stall and a saturating write-error counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 1024,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     fifo_full_i,
  input  logic                     fifo_wr_error_i,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [ID_W-1:0]          grant_id_o,
  output logic                     busy_o,
  output logic [ERR_CNT_W-1:0]     err_cnt_o
);

  arb_state_e                     state;
  logic [ID_W-1:0]                owner, rr_ptr, owner_nxt, pick_idx;
  logic [7:0]                     beat_cnt;
  logic [ERR_CNT_W-1:0]           err_cnt;
  logic                           pick_found, in_grant, own_valid, beat, last_beat;
  logic [NUM_REQ-1:0][WIDTH-1:0]  req_data;

  assign req_data = req_data_i;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .valid (req_valid_i),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign in_grant  = (state == ARB_GRANT);
  assign own_valid = req_valid_i[owner];
  // Write qualifies on this cycle's full only; a stall holds the burst in place.
  assign beat      = in_grant & own_valid & ~fifo_full_i;
  assign last_beat = beat && (beat_cnt == 8'(MAX_BURST-1));
  assign owner_nxt = (owner == ID_W'(NUM_REQ-1)) ? '0 : owner + ID_W'(1);

  always_comb begin
    req_ready_o  = '0;
    grant_o      = '0;
    fifo_wdata_o = '0;
    if (in_grant) begin
      req_ready_o[owner] = ~fifo_full_i;
      grant_o[owner]     = 1'b1;
      fifo_wdata_o       = req_data[owner];
    end
  end

  assign fifo_wr_en_o = beat;
  assign busy_o       = in_grant;
  assign grant_id_o   = owner;
  assign err_cnt_o    = err_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!own_valid || last_beat) begin
            state  <= ARB_IDLE;
            rr_ptr <= owner_nxt;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              err_cnt <= '0;
    else if (fifo_wr_error_i && err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbitration rules.
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 32, MB = 4, IW = 2;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]     valid = '0;
  logic [N*W-1:0]   data = '0;
  logic             full = 1'b0, werr = 1'b0;
  logic [N-1:0]     ready, grant;
  logic             wr_en, busy;
  logic [W-1:0]     wdata;
  logic [IW-1:0]    gid;
  logic [15:0]      err_cnt;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB), .ID_W(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_data_i(data),
    .req_ready_o(ready), .fifo_full_i(full), .fifo_wr_error_i(werr),
    .fifo_wr_en_o(wr_en), .fifo_wdata_o(wdata), .grant_o(grant),
    .grant_id_o(gid), .busy_o(busy), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;

  // Model: who owns the port, how many beats taken, where the next search starts.
  bit m_busy;
  int m_owner, m_ptr, m_beats, m_err;
  logic [W-1:0] seq [N];
  bit use_seq = 1'b1;

  typedef struct { int cyc; int id; logic [W-1:0] d; } wr_t;
  wr_t wlog [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_oh;
    e_oh = m_busy ? (N'(1) << m_owner) : '0;
    chk("busy",    busy,    m_busy);
    chk("grant",   grant,   e_oh);
    chk("ready",   ready,   (m_busy && !full) ? e_oh : '0);
    chk("wr_en",   wr_en,   m_busy && valid[m_owner] && !full);
    chk("wdata",   wdata,   m_busy ? data[m_owner*W +: W] : '0);
    chk("err_cnt", err_cnt, m_err);
    if (m_busy) chk("grant_id", gid, m_owner);
  endtask

  task automatic model_step();
    if (m_busy && valid[m_owner] && !full) begin
      seq[m_owner]++;
      m_beats++;
      if (m_beats == MB) begin m_busy = 0; m_ptr = (m_owner + 1) % N; end
    end else if (m_busy && !valid[m_owner]) begin
      m_busy = 0; m_ptr = (m_owner + 1) % N;
    end else if (!m_busy) begin
      for (int i = N-1; i >= 0; i--)
        if (valid[(m_ptr + i) % N]) begin m_busy = 1; m_owner = (m_ptr + i) % N; end
      m_beats = 0;
    end
    if (werr && m_err < 65535) m_err++;
    cyc++;
  endtask

  // One clock: refresh data, check at mid-phase, advance model at the edge.
  task automatic tick();
    if (use_seq) for (int k = 0; k < N; k++) data[k*W +: W] = seq[k];
    #1;
    check_outputs();
    if (wr_en) wlog.push_back('{cyc, int'(gid), wdata});
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_err = 0;
    for (int k = 0; k < N; k++) seq[k] = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; full = 1'b0; werr = 1'b0; use_seq = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    wlog.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_gid", gid, 0);
    chk("rst_err", err_cnt, 0);

    // Single producer: two 4-beat bursts with one IDLE bubble.
    valid = 4'b0010;
    repeat (12) tick();
    chk("t1_nbeats", wlog.size() >= 8, 1);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      chk("t1_data", wlog[i].d, i + 1);
      chk("t1_id",   wlog[i].id, 1);
      chk("t1_cyc",  wlog[i].cyc, (i < 4) ? i + 1 : i + 2);
    end

    // Round-robin fairness: all valid, order 0,1,2,3,0.
    do_reset();
    valid = '1;
    repeat (25) tick();
    chk("t2_nbeats", wlog.size() >= 20, 1);
    for (int i = 0; i < 20 && i < wlog.size(); i++) begin
      chk("t2_id",  wlog[i].id, (i / 4) % 4);
      chk("t2_cyc", wlog[i].cyc, 1 + i + i / 4);
    end

    // Full stall mid-burst: owner 2 keeps the grant, finishes remaining 2 beats.
    do_reset();
    valid = 4'b0100;
    repeat (3) tick();
    full = 1'b1;
    repeat (5) begin
      #1;
      chk("t3_stall_wr",  wr_en, 0);
      chk("t3_stall_rdy", ready, 0);
      chk("t3_stall_gid", gid, 2);
      tick();
    end
    full = 1'b0;
    repeat (6) tick();
    chk("t3_nbeats", wlog.size() >= 5, 1);
    if (wlog.size() >= 5) begin
      chk("t3_b2", wlog[1].cyc, 2);
      chk("t3_b3", wlog[2].cyc, 8);
      chk("t3_b4", wlog[3].cyc, 9);
      chk("t3_next", wlog[4].cyc, 11);
    end

    // Early release by owner 3 while requester 0 waits.
    do_reset();
    valid = 4'b1000; tick();
    valid = 4'b1001; tick();
    valid = 4'b0001; tick();
    #1 chk("t4_bubble", busy, 0);
    tick();
    #1 chk("t4_grant0", grant, 4'b0001);
    tick();

    // Wrap: after owner 2 finishes, pointer sits at 3 and only 0 is valid.
    do_reset();
    valid = 4'b0100;
    repeat (5) tick();
    valid = 4'b0001; tick();
    #1;
    chk("t5_wrap_grant", grant, 4'b0001);
    chk("t5_wrap_gid", gid, 0);
    tick();

    // Async reset between edges during GRANT.
    do_reset();
    valid = '1;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_grant", grant, 0);
    chk("ar_ready", ready, 0);
    chk("ar_wr_en", wr_en, 0);
    chk("ar_wdata", wdata, 0);
    chk("ar_gid", gid, 0);
    model_reset();
    @(negedge clk);
    valid = 4'b0110;
    rst_n = 1'b1;
    cyc = 0;
    tick();
    #1;
    chk("ar_first_gid", gid, 1);
    chk("ar_first_grant", grant, 4'b0010);
    tick();

    // Random traffic.
    do_reset();
    use_seq = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) valid[k] = ~valid[k];
        data[k*W +: W] = $urandom;
      end
      full = ($urandom_range(0, 3) == 0);
      werr = ($urandom_range(0, 15) == 0);
      tick();
    end

    // Error counter: count, approach the top, saturate.
    do_reset();
    werr = 1'b1; repeat (3) tick();
    werr = 1'b0; tick();
    chk("err_3", err_cnt, 3);
    werr = 1'b1; repeat (65531) tick();
    werr = 1'b0; tick();
    chk("err_fffe", err_cnt, 16'hFFFE);
    werr = 1'b1; repeat (3) tick();
    werr = 1'b0; tick();
    chk("err_sat", err_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
